// File: rtl/ts_reader.sv
// Polling reader for an XPT2046 touchscreen ADC on a shared, arbitrated SPI bus.
// Takes Z1, X and Y conversions under one chip-select and publishes the touched coordinates.
module ts_reader #(
    parameter int unsigned CLK_DIV       = 8,
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter logic [11:0] Z_THRESH      = 12'd100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        csn,
    output logic        busy,
    output logic        valid,
    output logic        touch,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [11:0] z
);

    localparam int unsigned TW = $clog2(SAMPLE_PERIOD + 1);
    localparam int unsigned DW = $clog2(CLK_DIV);

    localparam logic [TW-1:0] TIMER_RELOAD = TW'(SAMPLE_PERIOD);
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE      = DW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_UPDATE = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    conv_q, conv_d;
    logic [4:0]    pos_q, pos_d;
    logic [13:0]   rx_q, rx_d;
    logic [11:0]   zh_q, zh_d;
    logic [11:0]   xh_q, xh_d;
    logic [11:0]   yh_q, yh_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          csn_q, csn_d;
    logic          bus_req_q, bus_req_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          touch_q, touch_d;
    logic [11:0]   x_q, x_d;
    logic [11:0]   y_q, y_d;
    logic [11:0]   z_q, z_d;

    // Command bit driven on SCLK pos+1 of conversion conv; zero after the command byte.
    function automatic logic cmd_bit(input logic [1:0] conv, input logic [4:0] pos);
        logic [7:0] cmd;
        case (conv)
            2'd0:    cmd = 8'hB0;
            2'd1:    cmd = 8'hD0;
            default: cmd = 8'h90;
        endcase
        if (pos < 5'd8) cmd_bit = cmd[3'd7 - pos[2:0]];
        else            cmd_bit = 1'b0;
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        div_d   = div_q;
        conv_d  = conv_q;
        pos_d   = pos_q;
        rx_d    = rx_q;
        zh_d    = zh_q;
        xh_d    = xh_q;
        yh_d    = yh_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        touch_d = touch_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (timer_q == '0) begin
                        state_d = S_REQ;
                        timer_d = TIMER_RELOAD;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d = S_SETUP;
                    div_d   = DIV_LAST;
                    conv_d  = 2'd0;
                    pos_d   = 5'd0;
                    sclk_d  = 1'b0;
                    mosi_d  = cmd_bit(2'd0, 5'd0);
                end
            end
            S_SETUP: begin
                if (div_q == '0) begin
                    state_d = S_SHIFT;
                    div_d   = DIV_LAST;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_ONE;
                end else begin
                    div_d = DIV_LAST;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[12:0], miso};
                        // On edge 24 the window holds edges 10..23; result = edges 10..21.
                        if (pos_q == 5'd23) begin
                            case (conv_q)
                                2'd0:    zh_d = rx_q[13:2];
                                2'd1:    xh_d = rx_q[13:2];
                                default: yh_d = rx_q[13:2];
                            endcase
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (pos_q == 5'd23) begin
                            pos_d = 5'd0;
                            if (conv_q == 2'd2) begin
                                state_d = S_HOLD;
                                mosi_d  = 1'b0;
                            end else begin
                                conv_d = conv_q + 2'd1;
                                mosi_d = cmd_bit(conv_q + 2'd1, 5'd0);
                            end
                        end else begin
                            pos_d  = pos_q + 5'd1;
                            mosi_d = cmd_bit(conv_q, pos_q + 5'd1);
                        end
                    end
                end
            end
            S_HOLD: begin
                if (div_q == '0) begin
                    // Results land with the valid pulse so they are stable while valid=1.
                    state_d = S_UPDATE;
                    z_d     = zh_q;
                    touch_d = (zh_q >= Z_THRESH);
                    if (zh_q >= Z_THRESH) begin
                        x_d = xh_q;
                        y_d = yh_q;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        csn_d     = !((state_d == S_SETUP) || (state_d == S_SHIFT));
        bus_req_d = (state_d == S_REQ) || (state_d == S_SETUP) ||
                    (state_d == S_SHIFT) || (state_d == S_HOLD);
        busy_d    = (state_d != S_IDLE);
        valid_d   = (state_d == S_UPDATE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= TIMER_RELOAD;
            div_q     <= '0;
            conv_q    <= '0;
            pos_q     <= '0;
            rx_q      <= '0;
            zh_q      <= '0;
            xh_q      <= '0;
            yh_q      <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            csn_q     <= 1'b1;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            touch_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            conv_q    <= conv_d;
            pos_q     <= pos_d;
            rx_q      <= rx_d;
            zh_q      <= zh_d;
            xh_q      <= xh_d;
            yh_q      <= yh_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            csn_q     <= csn_d;
            bus_req_q <= bus_req_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            touch_q   <= touch_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign csn     = csn_q;
    assign bus_req = bus_req_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign touch   = touch_q;
    assign x       = x_q;
    assign y       = y_q;
    assign z       = z_q;

endmodule

// File: tb/tb_ts_reader.sv
// Directed bench for ts_reader: XPT2046 ADC model, table-driven polls and hand-written corner cases.
module tb_ts_reader;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned SP      = 10;
    localparam int unsigned LATENCY = CLK_DIV + 144 * CLK_DIV + CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        bus_gnt = 1'b1;
    logic        miso;
    logic        bus_req, sclk, mosi, csn, busy, valid, touch;
    logic [11:0] x, y, z;

    int unsigned checks = 0;
    int unsigned errors = 0;

    ts_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .Z_THRESH(12'd100)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .sclk(sclk), .mosi(mosi), .miso(miso), .csn(csn), .busy(busy), .valid(valid),
        .touch(touch), .x(x), .y(y), .z(z)
    );

    always #5 clk = ~clk;

    // ADC model: rise_cnt counts SCLK rises since csn fell; miso presents the bit for the next rise.
    logic [11:0] mz = '0, mx = '0, my = '0;
    logic        m_ones = 1'b0;
    int unsigned rise_cnt = 0;
    int unsigned stray = 0;
    logic [71:0] mosi_cap = '0;

    always @(posedge sclk or negedge csn) begin
        if (sclk) begin
            if (csn) stray = stray + 1;
            else begin
                if (rise_cnt < 72) mosi_cap[rise_cnt] = mosi;
                rise_cnt = rise_cnt + 1;
            end
        end else begin
            rise_cnt = 0;
        end
    end

    function automatic logic miso_fn(input int unsigned n, input logic [11:0] a, b, c,
                                     input logic ones);
        int unsigned k;
        logic [11:0] v;
        if (ones) return 1'b1;
        if (n >= 72) return 1'b0;
        k = n % 24 + 1;
        v = (n < 24) ? a : (n < 48) ? b : c;
        if (k >= 10 && k <= 21) return v[21 - k];
        return 1'b0;
    endfunction

    assign miso = miso_fn(rise_cnt, mz, mx, my, m_ones);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int unsigned budget, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [23:0] frame_of(input logic [71:0] cap, input int unsigned c);
        logic [23:0] f;
        for (int unsigned i = 0; i < 24; i++) f[23 - i] = cap[c * 24 + i];
        return f;
    endfunction

    typedef struct {
        logic [11:0] mz, mx, my;
        logic        ones;
        logic [11:0] ez;
        logic        et;
        logic [11:0] ex, ey;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit          seen;
        int unsigned n;
        int unsigned bad;

        vecs[0] = '{12'h200, 12'hABC, 12'h123, 1'b0, 12'h200, 1'b1, 12'hABC, 12'h123};
        vecs[1] = '{12'h050, 12'h111, 12'h222, 1'b0, 12'h050, 1'b0, 12'hABC, 12'h123};
        vecs[2] = '{12'h064, 12'h456, 12'h789, 1'b0, 12'h064, 1'b1, 12'h456, 12'h789};
        vecs[3] = '{12'h063, 12'hAAA, 12'hBBB, 1'b0, 12'h063, 1'b0, 12'h456, 12'h789};
        vecs[4] = '{12'h000, 12'h000, 12'h000, 1'b1, 12'hFFF, 1'b1, 12'hFFF, 12'hFFF};
        vecs[5] = '{12'h000, 12'h321, 12'h654, 1'b0, 12'h000, 1'b0, 12'hFFF, 12'hFFF};

        mz = vecs[0].mz; mx = vecs[0].mx; my = vecs[0].my; m_ones = vecs[0].ones;

        // Reset state with enable high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csn", 32'(csn), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xyz", {x, y, z[7:0]}, 32'd0);

        @(negedge clk) rst_n = 1'b1;
        n = 0;
        for (int unsigned i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                n = i;
                break;
            end
        end
        chk("bus_req_delay", n, SP + 1);

        // Table of polls, grant tied high
        for (int unsigned i = 0; i < 6; i++) begin
            mz = vecs[i].mz; mx = vecs[i].mx; my = vecs[i].my; m_ones = vecs[i].ones;
            wait_valid(3000, seen);
            chk($sformatf("v%0d_valid_seen", i), 32'(seen), 32'd1);
            chk($sformatf("v%0d_z", i), 32'(z), 32'(vecs[i].ez));
            chk($sformatf("v%0d_touch", i), 32'(touch), 32'(vecs[i].et));
            chk($sformatf("v%0d_x", i), 32'(x), 32'(vecs[i].ex));
            chk($sformatf("v%0d_y", i), 32'(y), 32'(vecs[i].ey));
            chk($sformatf("v%0d_sclk_rises", i), rise_cnt, 32'd72);
            chk($sformatf("v%0d_stray_rises", i), stray, 32'd0);
            chk($sformatf("v%0d_cmd_z1", i), 32'(frame_of(mosi_cap, 0)), 32'h00B00000);
            chk($sformatf("v%0d_cmd_x", i), 32'(frame_of(mosi_cap, 1)), 32'h00D00000);
            chk($sformatf("v%0d_cmd_y", i), 32'(frame_of(mosi_cap, 2)), 32'h00900000);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_width", i), 32'(valid), 32'd0);
        end

        // Grant delayed 500 clk
        @(negedge clk) bus_gnt = 1'b0;
        mz = 12'h300; mx = 12'h0F0; my = 12'h00F; m_ones = 1'b0;
        seen = 1'b0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("gnt_req_seen", 32'(seen), 32'd1);
        bad = 0;
        for (int unsigned i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (csn !== 1'b1 || sclk !== 1'b0 || bus_req !== 1'b1) bad = bad + 1;
        end
        chk("gnt_wait_idle_pins", bad, 32'd0);
        @(negedge clk) bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        chk("gnt_csn_fall", 32'(csn), 32'd0);
        n = 0;
        for (int unsigned i = 2; i <= 2000; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                n = i;
                break;
            end
        end
        chk("gnt_to_valid_latency", n, LATENCY);
        chk("gnt_x", 32'(x), 32'h0F0);
        chk("gnt_y", 32'(y), 32'h00F);

        // Enable dropped mid-poll
        seen = 1'b0;
        for (int unsigned i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (!csn && rise_cnt >= 30) begin
                seen = 1'b1;
                break;
            end
        end
        chk("en_drop_reached_sclk30", 32'(seen), 32'd1);
        enable = 1'b0;
        wait_valid(3000, seen);
        chk("en_drop_poll_completes", 32'(seen), 32'd1);
        bad = 0;
        for (int unsigned i = 0; i < 3 * SP; i++) begin
            @(posedge clk);
            #1;
            if (bus_req !== 1'b0 || busy !== 1'b0) bad = bad + 1;
        end
        chk("en_drop_stays_idle", bad, 32'd0);
        enable = 1'b1;

        // Asynchronous reset mid-transaction
        seen = 1'b0;
        for (int unsigned i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (!csn && rise_cnt >= 40) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached_sclk40", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_csn", 32'(csn), 32'd1);
        chk("rst_mid_sclk", 32'(sclk), 32'd0);
        chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
        chk("rst_mid_xyz", {8'h00, x, y} | 32'(z), 32'd0);
        chk("rst_mid_touch", 32'(touch), 32'd0);
        bad = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b0) bad = bad + 1;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b0) bad = bad + 1;
        end
        chk("rst_mid_no_valid", bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
